ctl_seq: RTL and testbench

Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB RV32 datapath. It replaces the per-instruction hand-driven stimulus with a finite state machine. The FSM steps each instruction through IF/ID/EX/MEM/WB phases, drives the datapath control strobes and ALU op, and owns the PC register (next PC from PCp4, branch or jTarget). It also detects unsupported opcodes and halts, and counts retired instructions.

---
 rtl/ctl_pkg.sv | 45 ++++
 rtl/ctl_seq_if.sv | 38 +++
 rtl/ctl_decode.sv | 76 +++++++
 rtl/ctl_seq.sv | 130 +++++++++++++
 tb/tb_ctl_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctl_pkg.sv
// ctl_pkg: shared types and constants for the ctl_seq sequencer.
//   state_e   - FSM state encoding (IF, ID, EX, MEM, WB, HALT)
//   iclass_e  - decoded instruction class
//   OPC_*     - RV32 major opcodes recognised by the decoder
//   ALU_*     - ALU operation codes driven to yEX
package ctl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_R     = 3'd0,
    CL_IALU  = 3'd1,
    CL_LOAD  = 3'd2,
    CL_STORE = 3'd3,
    CL_BEQ   = 3'd4,
    CL_JAL   = 3'd5,
    CL_ILL   = 3'd6
  } iclass_e;

  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_IALU  = 7'h13;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BEQ   = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Classes that finish in EX (no MEM/WB phase).
  function automatic logic ends_in_ex(input iclass_e cls);
    return (cls == CL_BEQ) || (cls == CL_JAL);
  endfunction

endpackage

// File: rtl/ctl_seq_if.sv
// ctl_seq_if: datapath-facing signals of the ctl_seq sequencer.
//   master - datapath side (drives run, ins, zero, PCp4, branch, jTarget)
//   slave  - sequencer side (drives PCin, control strobes, op, retire,
//            icount, trap)
// CNT_W must match the CNT_W of the ctl_seq instance it connects to.
interface ctl_seq_if #(parameter int CNT_W = 16);

  logic             run;
  logic [31:0]      ins;
  logic             zero;
  logic [31:0]      PCp4;
  logic [31:0]      branch;
  logic [31:0]      jTarget;

  logic [31:0]      PCin;
  logic             RegWrite;
  logic             ALUSrc;
  logic [2:0]       op;
  logic             MemRead;
  logic             MemWrite;
  logic             Mem2Reg;
  logic             retire;
  logic [CNT_W-1:0] icount;
  logic             trap;

  modport master (
    output run, ins, zero, PCp4, branch, jTarget,
    input  PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
           retire, icount, trap
  );

  modport slave (
    input  run, ins, zero, PCp4, branch, jTarget,
    output PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
           retire, icount, trap
  );

endinterface

// File: rtl/ctl_decode.sv
// ctl_decode: combinational instruction decoder for ctl_seq.
//   i_ins     in  32  instruction word
//   o_class   out     instruction class (CL_ILL for anything unsupported)
//   o_op      out 3   ALU operation
//   o_alusrc  out 1   ALU B-operand select (0 = rd2, 1 = imm)
// Build option: CTL_SEQ_JAL_EN decodes opcode 6F as JAL; without it 6F
// is illegal.
module ctl_decode
  import ctl_pkg::*;
(
  input  logic [31:0] i_ins,
  output iclass_e     o_class,
  output logic [2:0]  o_op,
  output logic        o_alusrc
);

`ifdef CTL_SEQ_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opc = i_ins[6:0];
  assign w_f3  = i_ins[14:12];
  assign w_f7  = i_ins[31:25];

  always_comb begin
    o_class  = CL_ILL;
    o_op     = ALU_ADD;
    o_alusrc = 1'b0;
    case (w_opc)
      OPC_R: begin
        o_class = CL_R;
        // Only the five supported R functions; everything else traps.
        case ({w_f7, w_f3})
          10'b0000000_000: o_op = ALU_ADD;
          10'b0100000_000: o_op = ALU_SUB;
          10'b0000000_111: o_op = ALU_AND;
          10'b0000000_110: o_op = ALU_OR;
          10'b0000000_010: o_op = ALU_SLT;
          default:         o_class = CL_ILL;
        endcase
      end
      OPC_IALU: begin
        o_class  = CL_IALU;
        o_alusrc = 1'b1;
      end
      OPC_LOAD: begin
        o_class  = CL_LOAD;
        o_alusrc = 1'b1;
      end
      OPC_STORE: begin
        o_class  = CL_STORE;
        o_alusrc = 1'b1;
      end
      OPC_BEQ: begin
        if (w_f3 == 3'b000) begin
          o_class = CL_BEQ;
          o_op    = ALU_SUB;
        end
      end
      OPC_JAL: begin
        if (JAL_EN) begin
          o_class  = CL_JAL;
          o_alusrc = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctl_seq.sv
// ctl_seq: multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB
// RV32 datapath. Steps each instruction through its phases, drives the
// datapath strobes and ALU op, owns the PC and a retired-instruction
// counter, and halts with a sticky trap on unsupported instructions.
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of ctl_seq_if (run/ins/zero/PCp4/branch/jTarget
//           in; PCin/RegWrite/ALUSrc/op/MemRead/MemWrite/Mem2Reg/retire/
//           icount/trap out)
// Build option: CTL_SEQ_JAL_EN enables JAL (see ctl_decode).
//
// state | meaning
// IF    | wait for run, PC stable for fetch
// ID    | decode; illegal instructions go to HALT
// EX    | ALU phase; last phase for BEQ/JAL
// MEM   | data-memory phase for LOAD/STORE; last phase for STORE
// WB    | register writeback for R/IALU/LOAD
// HALT  | absorbing trap state, left only by reset
module ctl_seq
  import ctl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h28,
  parameter int          CNT_W    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  ctl_seq_if.slave bus
);

  localparam logic [2:0] S_IF   = ST_IF;
  localparam logic [2:0] S_ID   = ST_ID;
  localparam logic [2:0] S_EX   = ST_EX;
  localparam logic [2:0] S_MEM  = ST_MEM;
  localparam logic [2:0] S_WB   = ST_WB;
  localparam logic [2:0] S_HALT = ST_HALT;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic [CNT_W-1:0] r_icnt;
  logic             r_trap;
  logic             w_last;

  iclass_e          w_class;
  logic [2:0]       w_op;
  logic             w_alusrc;

  ctl_decode u_decode (
    .i_ins    (bus.ins),
    .o_class  (w_class),
    .o_op     (w_op),
    .o_alusrc (w_alusrc)
  );

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_EX:    w_last = ends_in_ex(w_class);
      S_MEM:   w_last = (w_class == CL_STORE);
      S_WB:    w_last = 1'b1;
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IF:    w_state_nxt = bus.run ? S_ID : S_IF;
      S_ID:    w_state_nxt = (w_class == CL_ILL) ? S_HALT : S_EX;
      S_EX: begin
        if (ends_in_ex(w_class))
          w_state_nxt = S_IF;
        else if ((w_class == CL_LOAD) || (w_class == CL_STORE))
          w_state_nxt = S_MEM;
        else
          w_state_nxt = S_WB;
      end
      S_MEM:   w_state_nxt = (w_class == CL_LOAD) ? S_WB : S_IF;
      S_WB:    w_state_nxt = S_IF;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
  end

  // zero only matters here, on the edge leaving EX of a BEQ.
  always_comb begin
    if ((w_class == CL_BEQ) && bus.zero)
      w_pc_nxt = bus.branch;
    else if (w_class == CL_JAL)
      w_pc_nxt = bus.jTarget;
    else
      w_pc_nxt = bus.PCp4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IF;
      r_pc    <= RESET_PC;
      r_icnt  <= '0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_last) begin
        r_pc   <= w_pc_nxt;
        r_icnt <= r_icnt + CNT_W'(1);
      end
      if ((r_state == S_ID) && (w_class == CL_ILL))
        r_trap <= 1'b1;
    end
  end

  // Strobes come straight from the state register, so an async reset
  // drops them immediately. WB is only reachable by writing classes.
  assign bus.RegWrite = (r_state == S_WB);
  assign bus.MemRead  = (w_class == CL_LOAD) &&
                        ((r_state == S_MEM) || (r_state == S_WB));
  assign bus.MemWrite = (w_class == CL_STORE) && (r_state == S_MEM);
  assign bus.Mem2Reg  = (w_class == CL_LOAD) && (r_state == S_WB);
  assign bus.retire   = w_last;
  assign bus.op       = ((r_state == S_EX) || (r_state == S_MEM) ||
                         (r_state == S_WB)) ? w_op : 3'b000;
  assign bus.ALUSrc   = ((r_state == S_ID) || (r_state == S_EX) ||
                         (r_state == S_MEM) || (r_state == S_WB)) ?
                        w_alusrc : 1'b0;
  assign bus.PCin     = r_pc;
  assign bus.icount   = r_icnt;
  assign bus.trap     = r_trap;

endmodule

// File: tb/tb_ctl_seq.sv
module tb_ctl_seq;

  localparam int CW = 4;

  localparam int C_R = 0, C_IALU = 1, C_LOAD = 2, C_STORE = 3,
                 C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctl_seq_if #(.CNT_W(CW)) bus ();

  ctl_seq #(.RESET_PC(32'h28), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0]   exp_pc  = 32'h28;
  logic [CW-1:0] exp_cnt = '0;

  // Reference classification straight from the opcode/funct rules.
  function automatic int ref_class(input logic [31:0] i);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    if (opc == 7'h33) begin
      if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2)) return C_R;
      if (f7 == 7'h20 && f3 == 3'd0) return C_R;
      return C_ILL;
    end
    if (opc == 7'h13) return C_IALU;
    if (opc == 7'h03) return C_LOAD;
    if (opc == 7'h23) return C_STORE;
    if (opc == 7'h63) return (f3 == 3'd0) ? C_BEQ : C_ILL;
`ifdef CTL_SEQ_JAL_EN
    if (opc == 7'h6F) return C_JAL;
`endif
    return C_ILL;
  endfunction

  function automatic logic [2:0] ref_op(input logic [31:0] i);
    int c;
    c = ref_class(i);
    if (c == C_BEQ) return 3'b110;
    if (c != C_R) return 3'b010;
    if (i[31:25] == 7'h20) return 3'b110;
    case (i[14:12])
      3'd7:    return 3'b000;
      3'd6:    return 3'b001;
      3'd2:    return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] v;
    int pick, sel;
    v = $urandom;
`ifdef CTL_SEQ_JAL_EN
    pick = $urandom_range(0, 5);
`else
    pick = $urandom_range(0, 4);
`endif
    case (pick)
      0: begin
        v[6:0] = 7'h33;
        sel = $urandom_range(0, 4);
        v[31:25] = (sel == 1) ? 7'h20 : 7'h00;
        case (sel)
          0, 1: v[14:12] = 3'd0;
          2:    v[14:12] = 3'd7;
          3:    v[14:12] = 3'd6;
          default: v[14:12] = 3'd2;
        endcase
      end
      1: v[6:0] = 7'h13;
      2: v[6:0] = 7'h03;
      3: v[6:0] = 7'h23;
      4: begin v[6:0] = 7'h63; v[14:12] = 3'd0; end
      default: v[6:0] = 7'h6F;
    endcase
    return v;
  endfunction

  // Runs one legal instruction starting in IF (called just after a
  // rising edge) and checks every cycle against the class-based model.
  task automatic run_instr(input logic [31:0] ins, input logic z,
                           input logic [31:0] br, input logic [31:0] jt,
                           input string tag);
    int cls, lat;
    logic [31:0] pcp4;
    logic [7:0] got, want;
    logic [2:0] eop;
    logic esrc;
    cls  = ref_class(ins);
    lat  = (cls == C_LOAD) ? 5 : ((cls == C_BEQ || cls == C_JAL) ? 3 : 4);
    esrc = !(cls == C_R || cls == C_BEQ);
    pcp4 = exp_pc + 32'd4;
    bus.ins = ins; bus.zero = z; bus.PCp4 = pcp4;
    bus.branch = br; bus.jTarget = jt; bus.run = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      eop  = (k == 3) ? ref_op(ins) : 3'b000;
      want = {(cls == C_R || cls == C_IALU || cls == C_LOAD) && (k == lat),
              (cls == C_LOAD) && (k >= 4),
              (cls == C_STORE) && (k == 4),
              (cls == C_LOAD) && (k == 5),
              (k == lat),
              eop};
      got  = {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Mem2Reg, bus.retire,
              (k <= 3) ? bus.op : 3'b000};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s strobes ins=%h cyc%0d got=%b want=%b", tag, ins, k, got, want);
      end
      if (k >= 2) begin
        total++;
        if (bus.ALUSrc !== esrc) begin
          bad++;
          $display("FAIL %s alusrc ins=%h cyc%0d got=%b want=%b", tag, ins, k, bus.ALUSrc, esrc);
        end
      end
      if (k == 2) bus.run = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    if (cls == C_BEQ && z) exp_pc = br;
    else if (cls == C_JAL) exp_pc = jt;
    else exp_pc = pcp4;
    exp_cnt = exp_cnt + 1'b1;
    total++;
    if (bus.PCin !== exp_pc) begin
      bad++;
      $display("FAIL %s pc ins=%h got=%h want=%h", tag, ins, bus.PCin, exp_pc);
    end
    total++;
    if (bus.icount !== exp_cnt) begin
      bad++;
      $display("FAIL %s icount ins=%h got=%0d want=%0d", tag, ins, bus.icount, exp_cnt);
    end
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    exp_pc = 32'h28; exp_cnt = '0;
  endtask

  task automatic test_reset();
    logic [9:0] s;
    bus.run = 1'b0; bus.ins = 32'h00A50533; bus.zero = 1'b0;
    bus.PCp4 = 32'h0; bus.branch = 32'h0; bus.jTarget = 32'h0;
    #12;
    s = {bus.RegWrite, bus.ALUSrc, bus.op, bus.MemRead, bus.MemWrite,
         bus.Mem2Reg, bus.retire, bus.trap};
    total++; if (bus.PCin !== 32'h28) begin bad++; $display("FAIL reset_pc got=%h want=%h", bus.PCin, 32'h28); end
    total++; if (bus.icount !== '0) begin bad++; $display("FAIL reset_icount got=%0d want=0", bus.icount); end
    total++; if (bus.trap !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b want=0", bus.trap); end
    total++; if (s !== '0) begin bad++; $display("FAIL reset_strobes got=%b want=0", s); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_instr(32'h00A50533, 1'b0, 32'h0, 32'h0, "r_add");
    run_instr(32'h00002283, 1'b0, 32'h0, 32'h0, "load");
    run_instr(32'h00000463, 1'b1, 32'h40, 32'h0, "beq_taken");
    total++; if (bus.PCin !== 32'h40) begin bad++; $display("FAIL beq_target got=%h want=%h", bus.PCin, 32'h40); end
    run_instr(32'h00000463, 1'b0, 32'h80, 32'h0, "beq_not_taken");
    total++; if (bus.PCin !== 32'h44) begin bad++; $display("FAIL beq_fallthru got=%h want=%h", bus.PCin, 32'h44); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_instr(rand_ins(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                $urandom & 32'hFFFF_FFFC, "random");
  endtask

  task automatic test_run_hold();
    logic [9:0] s;
    bus.run = 1'b0;
    bus.ins = 32'h00002283;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      s = {bus.RegWrite, bus.ALUSrc, bus.op, bus.MemRead, bus.MemWrite,
           bus.Mem2Reg, bus.retire, bus.trap};
      total++;
      if (s !== '0 || bus.PCin !== exp_pc || bus.icount !== exp_cnt) begin
        bad++;
        $display("FAIL run_hold cyc%0d strobes=%b pc=%h want_pc=%h cnt=%0d want_cnt=%0d",
                 n, s, bus.PCin, exp_pc, bus.icount, exp_cnt);
      end
      @(posedge clk); #1;
    end
    run_instr(32'h00002283, 1'b0, 32'h0, 32'h0, "after_hold");
  endtask

  task automatic test_reset_mid();
    bus.ins = 32'h0020A023; bus.zero = 1'b0; bus.PCp4 = exp_pc + 32'd4; bus.run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.MemWrite !== 1'b1) begin bad++; $display("FAIL mid_memwrite got=%b want=1", bus.MemWrite); end
    #2; rst_n = 1'b0; bus.run = 1'b0;
    #1;
    total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL mid_abort_memwrite got=%b want=0", bus.MemWrite); end
    total++; if (bus.PCin !== 32'h28) begin bad++; $display("FAIL mid_abort_pc got=%h want=%h", bus.PCin, 32'h28); end
    total++; if (bus.icount !== '0) begin bad++; $display("FAIL mid_abort_icount got=%0d want=0", bus.icount); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_pc = 32'h28; exp_cnt = '0;
    run_instr(32'h00100093, 1'b0, 32'h0, 32'h0, "after_abort");
  endtask

  task automatic test_illegal();
    logic [31:0] ill [5];
    logic [9:0] s;
    ill[0] = 32'h0000007F; ill[1] = 32'h00001033; ill[2] = 32'h00001463;
    ill[3] = 32'h4000F033; ill[4] = 32'h0000006F;
    for (int e = 0; e < 5; e++) begin
      if (ref_class(ill[e]) != C_ILL) continue;
      run_instr(rand_ins(), 1'b0, 32'h100, 32'h200, "pre_illegal");
      bus.ins = ill[e]; bus.run = 1'b1;
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        s = {bus.RegWrite, 1'b0, bus.op, bus.MemRead, bus.MemWrite,
             bus.Mem2Reg, bus.retire, bus.trap};
        total++;
        if (s !== '0) begin bad++; $display("FAIL illegal_pre ins=%h cyc%0d got=%b want=0", ill[e], k, s); end
        @(posedge clk); #1;
      end
      total++; if (bus.trap !== 1'b1) begin bad++; $display("FAIL trap_set ins=%h got=%b want=1", ill[e], bus.trap); end
      for (int n = 0; n < 10; n++) begin
        bus.ins = rand_ins(); bus.run = 1'b1; bus.zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        s = {bus.RegWrite, bus.ALUSrc, bus.op, bus.MemRead, bus.MemWrite,
             bus.Mem2Reg, bus.retire, 1'b0};
        total++;
        if (s !== '0 || bus.trap !== 1'b1 || bus.PCin !== exp_pc || bus.icount !== exp_cnt) begin
          bad++;
          $display("FAIL halt_frozen cyc%0d strobes=%b trap=%b pc=%h want_pc=%h cnt=%0d want_cnt=%0d",
                   n, s, bus.trap, bus.PCin, exp_pc, bus.icount, exp_cnt);
        end
        @(posedge clk); #1;
      end
      do_reset();
      total++; if (bus.trap !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b want=0", bus.trap); end
      run_instr(32'h00A50533, 1'b0, 32'h0, 32'h0, "after_halt");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 16; n++)
      run_instr(32'h00100093, 1'b0, 32'h0, 32'h0, "wrap");
    total++;
    if (bus.icount !== '0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", bus.icount); end
    total++;
    if (bus.PCin !== 32'h28 + 32'd64) begin bad++; $display("FAIL wrap_pc got=%h want=%h", bus.PCin, 32'h28 + 32'd64); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_run_hold();
    test_reset_mid();
    test_illegal();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
